// File: rtl/updown_mod_counter_pkg.sv
// Shared counter types: wrap/saturate mode selector for counters, timers and prescalers.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package counter_pkg;

   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } cnt_mode_e;

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control/status bundle of the up/down modulo counter.
// Latency: n/a (wires only); q/evt/ovf are registered in the counter, at_limit is combinational.
// Backpressure: none; the counter accepts its controls every cycle.
//   master: drives en, up, mode, load, load_val, clr_ovf; observes q, at_limit, evt, ovf
//   slave : the counter itself
interface updown_mod_counter_if
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) ();

   logic             en;
   logic             up;
   cnt_mode_e        mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_ovf;
   logic [WIDTH-1:0] q;
   logic             at_limit;
   logic             evt;
   logic             ovf;

   modport master (
      output en, up, mode, load, load_val, clr_ovf,
      input  q, at_limit, evt, ovf
   );

   modport slave (
      input  en, up, mode, load, load_val, clr_ovf,
      output q, at_limit, evt, ovf
   );

endinterface

// File: rtl/updown_mod_counter_next.sv
// Next-count logic: one step up or down with wrap or saturate at 0 / max.
// Latency: purely combinational.
// Backpressure: none.
//   in : q (current count), up (direction), mode (wrap/sat), max (top count)
//   out: nxt (count after a step), bnd (q sits at the limit in the current direction)
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up,
   input  cnt_mode_e        mode,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] nxt,
   output logic             bnd
);

   always_comb begin
      bnd = up ? (q == max) : (q == '0);
      nxt = q;
      if (bnd) begin
         // At the limit: wrap jumps to the opposite end, saturate holds.
         if (mode == MODE_WRAP) begin
            nxt = up ? '0 : max;
         end
      end else begin
         nxt = up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MODULUS-1 with load, enable, wrap/saturate, event pulse, sticky ovf.
// Latency: q/evt/ovf update one clock after the sampling edge; at_limit is combinational.
// Backpressure: none; controls are sampled every cycle with priority rst > load > en.
//   clk, rst (sync, active-high) plain ports; bus (slave modport) carries controls and status.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH     = 4,
   parameter longint MODULUS   = 16,
   parameter longint RESET_VAL = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   updown_mod_counter_if.slave  bus
);

   localparam longint           MOD_LIMIT = longint'(1) << WIDTH;
   localparam logic [WIDTH-1:0] MAX       = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_Q     = WIDTH'(RESET_VAL);

   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be 1..32");
   end
   if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS must be 2..2**WIDTH");
   end
   if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("updown_mod_counter: RESET_VAL must be below MODULUS");
   end

   logic [WIDTH-1:0] q_r;
   logic             evt_r;
   logic             ovf_r;
   logic [WIDTH-1:0] nxt;
   logic             bnd;
   logic             bnd_evt;
   logic [WIDTH-1:0] ld_clamped;

   counter_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q    (q_r),
      .up   (bus.up),
      .mode (bus.mode),
      .max  (MAX),
      .nxt  (nxt),
      .bnd  (bnd)
   );

   // With a full binary range every load_val is already legal, so the
   // compare is only built when it can actually clip something.
   if (MODULUS < MOD_LIMIT) begin : g_clamp
      assign ld_clamped = (bus.load_val > MAX) ? MAX : bus.load_val;
   end else begin : g_noclamp
      assign ld_clamped = bus.load_val;
   end

   // A load in the same cycle suppresses the boundary event entirely.
   assign bnd_evt = bus.en & ~bus.load & bnd;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r   <= RST_Q;
         evt_r <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         if (bus.load) begin
            q_r <= ld_clamped;
         end else if (bus.en) begin
            q_r <= nxt;
         end
         evt_r <= bnd_evt;
         // Event beats a simultaneous clear.
         ovf_r <= bnd_evt | (ovf_r & ~bus.clr_ovf);
      end
   end

   assign bus.q        = q_r;
   assign bus.at_limit = bnd;
   assign bus.evt      = evt_r;
   assign bus.ovf      = ovf_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: two instances (mod 10 / reset 0, mod 16 / reset 5) share stimulus.
// Expected post-edge state is queued by the driver and checked by an independent monitor.
// Directed sequences cover wrap, saturate, clamp, load priority, ovf clear and reset; then random.
module tb_updown_mod_counter;
   import counter_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   updown_mod_counter_if #(.WIDTH(W)) ifa ();
   updown_mod_counter_if #(.WIDTH(W)) ifb ();

   updown_mod_counter #(.WIDTH(W), .MODULUS(10), .RESET_VAL(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   updown_mod_counter #(.WIDTH(W), .MODULUS(16), .RESET_VAL(5)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   typedef struct {
      int q;
      int evt;
      int ovf;
      int lim;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   int errors = 0;
   int checks = 0;

   // Reference state per instance: index 0 = dut_a, 1 = dut_b.
   int mq[2];
   int me[2];
   int mo[2];
   int mmax[2] = '{9, 15};
   int mrv[2]  = '{0, 5};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, expv, $time);
      end
   endtask

   // Counter behaviour stated as plain integer arithmetic on the range 0..max.
   function automatic exp_t model(input int k, input bit r, input bit en, input bit up,
                                  input bit sat, input bit ld, input int lv, input bit clr);
      exp_t e;
      bit   hit;
      if (r) begin
         mq[k] = mrv[k];
         me[k] = 0;
         mo[k] = 0;
      end else if (ld) begin
         mq[k] = (lv > mmax[k]) ? mmax[k] : lv;
         me[k] = 0;
         if (clr) mo[k] = 0;
      end else if (en) begin
         hit = up ? (mq[k] == mmax[k]) : (mq[k] == 0);
         if (hit) begin
            me[k] = 1;
            mo[k] = 1;
            if (!sat) mq[k] = up ? 0 : mmax[k];
         end else begin
            mq[k] = up ? mq[k] + 1 : mq[k] - 1;
            me[k] = 0;
            if (clr) mo[k] = 0;
         end
      end else begin
         me[k] = 0;
         if (clr) mo[k] = 0;
      end
      e.q   = mq[k];
      e.evt = me[k];
      e.ovf = mo[k];
      e.lim = up ? int'(mq[k] == mmax[k]) : int'(mq[k] == 0);
      return e;
   endfunction

   task automatic cyc(input bit r, input bit en, input bit up, input bit sat,
                      input bit ld, input int lv, input bit clr);
      @(negedge clk);
      rst          = r;
      ifa.en       = en;
      ifa.up       = up;
      ifa.mode     = cnt_mode_e'(sat);
      ifa.load     = ld;
      ifa.load_val = W'(lv);
      ifa.clr_ovf  = clr;
      ifb.en       = en;
      ifb.up       = up;
      ifb.mode     = cnt_mode_e'(sat);
      ifb.load     = ld;
      ifb.load_val = W'(lv);
      ifb.clr_ovf  = clr;
      qa.push_back(model(0, r, en, up, sat, ld, lv, clr));
      qb.push_back(model(1, r, en, up, sat, ld, lv, clr));
   endtask

   // Lets the edge that consumes the last cyc() pass before a directed check.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: the counter presents a new state every cycle; compare one entry per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_q",        32'(ifa.q),   e.q);
            chk("a_evt",      32'(ifa.evt), e.evt);
            chk("a_ovf",      32'(ifa.ovf), e.ovf);
            chk("a_at_limit", 32'(ifa.at_limit), e.lim);
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_q",        32'(ifb.q),   e.q);
            chk("b_evt",      32'(ifb.evt), e.evt);
            chk("b_ovf",      32'(ifb.ovf), e.ovf);
            chk("b_at_limit", 32'(ifb.at_limit), e.lim);
         end
      end
   end

   initial begin
      int t;
      ifa.en = 0; ifa.up = 0; ifa.mode = MODE_WRAP; ifa.load = 0; ifa.load_val = '0; ifa.clr_ovf = 0;
      ifb.en = 0; ifb.up = 0; ifb.mode = MODE_WRAP; ifb.load = 0; ifb.load_val = '0; ifb.clr_ovf = 0;

      // Count up with wrap through 9 -> 0.
      cyc(1, 0, 0, 0, 0, 0, 0);
      settle();
      chk("rst_q",   32'(ifa.q),   0);
      chk("rst_b_q", 32'(ifb.q),   5);
      chk("rst_ovf", 32'(ifa.ovf), 0);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0, 0);
      settle();
      chk("up_wrap_q",   32'(ifa.q),   2);
      chk("up_wrap_ovf", 32'(ifa.ovf), 1);

      // Load 3, count down in saturate mode and sit at 0.
      cyc(0, 0, 0, 1, 1, 3, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0, 0, 0);
      settle();
      chk("sat_q",   32'(ifa.q),        0);
      chk("sat_evt", 32'(ifa.evt),      1);
      chk("sat_lim", 32'(ifa.at_limit), 1);

      // Load clamp and load-over-enable priority.
      cyc(0, 0, 1, 0, 1, 14, 0);
      settle();
      chk("clamp_a_q", 32'(ifa.q), 9);
      chk("clamp_b_q", 32'(ifb.q), 14);
      cyc(0, 1, 1, 0, 1, 5, 0);
      settle();
      chk("load_wins_q", 32'(ifa.q), 5);

      // ovf clear alone, then clear colliding with a wrap.
      cyc(0, 0, 1, 0, 0, 0, 1);
      settle();
      chk("clr_ovf", 32'(ifa.ovf), 0);
      cyc(0, 0, 1, 0, 1, 9, 0);
      cyc(0, 1, 1, 0, 0, 0, 1);
      settle();
      chk("clr_vs_evt_ovf", 32'(ifa.ovf), 1);
      chk("clr_vs_evt_q",   32'(ifa.q),   0);

      // Reset mid-count overrides en and load.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0, 0);
      settle();
      chk("pre_rst_q", 32'(ifa.q), 6);
      cyc(1, 1, 1, 0, 1, 7, 0);
      settle();
      chk("mid_rst_q",   32'(ifa.q),   0);
      chk("mid_rst_evt", 32'(ifa.evt), 0);
      chk("mid_rst_ovf", 32'(ifa.ovf), 0);

      // Natural binary wrap downward on the mod-16 instance from reset value 5.
      cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 0, 0);
      settle();
      chk("nat_wrap_q",   32'(ifb.q),   15);
      chk("nat_wrap_evt", 32'(ifb.evt), 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      settle();
      chk("nat_after_q",   32'(ifb.q),   14);
      chk("nat_after_evt", 32'(ifb.evt), 0);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 39) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)),
             $urandom_range(0, 9) == 0);
      end

      // Drain: every queued expectation must be consumed within a few cycles.
      t = 0;
      while ((qa.size() > 0 || qb.size() > 0) && t < 10) begin
         @(posedge clk);
         #2;
         t++;
      end
      if (qa.size() > 0 || qb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d/%0d entries left, expected 0", qa.size(), qb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
